// File: rtl/xor_accum_chan.sv
// xor_accum_chan: multi-channel registered XOR accumulator with a
// valid/ready command input and a DEPTH-entry result FIFO on the output.
//
// Ports:
//   clock, reset              clock, async active-low reset
//   in_valid/in_ready         command handshake
//   in_chan, in_mode, in_data target channel, op (00 LOAD 01 XOR 10 XNOR 11 CLEAR), operand
//   out_valid/out_ready       result handshake (FIFO head)
//   out_chan, out_data        head channel and updated accumulator value
//   out_flag, out_err         head value all-ones; head addressed a channel >= NCH

// One channel's accumulator register.
module xor_accum_lane #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module xor_accum_chan #(
  parameter int W     = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chan,
  input  logic [1:0]    in_mode,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_chan,
  output logic [W-1:0]  out_data,
  output logic          out_flag,
  output logic          out_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [W-1:0]  data;
    logic          flag;
    logic          err;
  } entry_t;

  logic [NCH-1:0][W-1:0] acc;
  logic [W-1:0]          cur, nv;
  logic                  bad, push, pop;
  entry_t                push_e, head_e;
  entry_t                mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [NW-1:0]         count;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Channel indices past NCH exist only when NCH is not a power of two.
  assign bad = {1'b0, in_chan} >= (CW+1)'(NCH);

  // Mux by comparison so an out-of-range channel never indexes acc.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NCH; i++)
      if (in_chan == CW'(i)) cur = acc[i];
  end

  always_comb begin
    unique case (in_mode)
      2'b00:   nv = in_data;
      2'b01:   nv = cur ^ in_data;
      2'b10:   nv = ~(cur ^ in_data);
      default: nv = '0;
    endcase
  end

  always_comb begin
    push_e.chan = in_chan;
    push_e.data = bad ? '0 : nv;
    push_e.flag = bad ? 1'b0 : &nv;
    push_e.err  = bad;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    xor_accum_lane #(.W(W)) u_lane (
      .clock (clock),
      .reset (reset),
      .we    (push & ~bad & (in_chan == CW'(g))),
      .d     (nv),
      .q     (acc[g])
    );
  end

  // Storage needs no reset: the head fields are masked while empty.
  always_ff @(posedge clock)
    if (push) mem[tail] <= push_e;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == PW'(DEPTH-1)) ? '0 : tail + PW'(1);
      if (pop)  head <= (head == PW'(DEPTH-1)) ? '0 : head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: ;
      endcase
    end
  end

  assign in_ready  = count < NW'(DEPTH);
  assign out_valid = count != '0;
  assign head_e    = mem[head];
  assign out_chan  = out_valid ? head_e.chan : '0;
  assign out_data  = out_valid ? head_e.data : '0;
  assign out_flag  = out_valid & head_e.flag;
  assign out_err   = out_valid & head_e.err;
endmodule

// File: tb/tb_xor_accum_chan.sv
module tb_xor_accum_chan;
  localparam int W = 8, NCH = 3, DEPTH = 2, CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, out_flag, out_err;
  logic [CW-1:0] in_chan, out_chan;
  logic [1:0]    in_mode;
  logic [W-1:0]  in_data, out_data;

  xor_accum_chan #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .out_flag(out_flag), .out_err(out_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         chan;
    logic [7:0] data;
    bit         flag;
    bit         err;
  } ent_t;

  ent_t       q[$];
  logic [7:0] macc [NCH];
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: an accepted command yields one result from the op table.
  task automatic model_push(input int ch, input logic [1:0] md, input logic [7:0] d);
    ent_t e;
    logic [7:0] nv;
    if (ch >= NCH) begin
      e = '{ch, 8'h00, 1'b0, 1'b1};
    end else begin
      case (md)
        2'd0:    nv = d;
        2'd1:    nv = macc[ch] ^ d;
        2'd2:    nv = ~(macc[ch] ^ d);
        default: nv = 8'h00;
      endcase
      macc[ch] = nv;
      e = '{ch, nv, nv == 8'hFF, 1'b0};
    end
    q.push_back(e);
  endtask

  // One clock: drive after negedge, check before posedge, update model.
  task automatic cyc(input bit v, input int ch, input logic [1:0] md,
                     input logic [7:0] d, input bit ordy, output bit took);
    in_valid = v; in_chan = ch[CW-1:0]; in_mode = md; in_data = d; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_chan", out_chan, q[0].chan);
      chk("out_data", out_data, q[0].data);
      chk("out_flag", out_flag, q[0].flag);
      chk("out_err",  out_err,  q[0].err);
    end
    took = v && (q.size() < DEPTH);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (took) model_push(ch, md, d);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send(input int ch, input logic [1:0] md, input logic [7:0] d, input bit ordy);
    bit t = 0;
    for (int n = 0; n < 20 && !t; n++) cyc(1'b1, ch, md, d, ordy, t);
    if (!t) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit t;
    for (int n = 0; n < 10 && q.size() != 0; n++) cyc(1'b0, 0, 2'd0, 8'h00, 1'b1, t);
    if (q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit t;
    int ch, acc_n;
    logic [1:0] md;
    logic [7:0] d;
    bit pend;

    reset = 1'b0; in_valid = 1'b0; in_chan = '0; in_mode = '0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) macc[i] = 8'h00;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_out_flag", out_flag, 0);
    chk("rst_out_err", out_err, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // LOAD then XOR on channel 1
    send(1, 2'd0, 8'hA5, 1'b0);
    chk("tp_load", out_data, 8'hA5);
    send(1, 2'd1, 8'h0F, 1'b1);
    chk("tp_xor", out_data, 8'hAA);
    chk("tp_xor_flag", out_flag, 0);
    drain();

    // XNOR and CLEAR on channel 2, then probe every channel
    send(2, 2'd2, 8'h00, 1'b0);
    chk("tp_xnor", out_data, 8'hFF);
    chk("tp_xnor_flag", out_flag, 1);
    drain();
    send(2, 2'd3, 8'h77, 1'b0);
    chk("tp_clear", out_data, 8'h00);
    chk("tp_clear_flag", out_flag, 0);
    drain();
    for (int i = 0; i < NCH; i++) send(i, 2'd1, 8'h00, 1'b1);
    drain();

    // Backpressure with three commands
    send(0, 2'd0, 8'h11, 1'b0);
    send(1, 2'd0, 8'h22, 1'b0);
    chk("bp_full_in_ready", in_ready, 0);
    cyc(1'b1, 2, 2'd0, 8'h33, 1'b0, t);
    chk("bp_stall", t, 0);
    cyc(1'b1, 2, 2'd0, 8'h33, 1'b1, t);
    chk("bp_pop_cycle", t, 0);
    cyc(1'b1, 2, 2'd0, 8'h33, 1'b0, t);
    chk("bp_third_accept", t, 1);
    drain();

    // Full FIFO, then continuous push and pop
    send(0, 2'd1, 8'h01, 1'b0);
    send(1, 2'd1, 8'h02, 1'b0);
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i % NCH, 2'd1, 8'(i * 7), 1'b1, t);
      if (t) acc_n++;
    end
    chk("steady_accepts", acc_n, 9);
    drain();

    // Out-of-range channel
    send(3, 2'd0, 8'h55, 1'b0);
    chk("err_flag", out_err, 1);
    chk("err_chan", out_chan, 3);
    chk("err_data", out_data, 0);
    drain();
    for (int i = 0; i < NCH; i++) send(i, 2'd1, 8'h00, 1'b1);
    drain();

    // Reset with two entries queued
    send(0, 2'd0, 8'h5A, 1'b0);
    send(1, 2'd1, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    for (int i = 0; i < NCH; i++) macc[i] = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    send(0, 2'd1, 8'h00, 1'b0);
    chk("post_rst_acc0", out_data, 8'h00);
    chk("post_rst_chan", out_chan, 0);
    drain();

    // Randomized traffic; a stalled command is held until accepted
    pend = 0; ch = 0; md = 0; d = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        ch   = $urandom_range(0, 3);
        md   = 2'($urandom_range(0, 3));
        d    = 8'($urandom);
      end
      cyc(pend, ch, md, d, $urandom_range(0, 9) < 6, t);
      if (t) pend = 0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
